cmd_arbiter: RTL and testbench
==============================

Name: cmd_arbiter

Overview:
- Shares the single command-processor interface (cmd / cmd_rdy / clr_cmd_rdy / send_resp / resp) between NUM_REQ requesters, for example the UART host, the tour command generator and a diagnostic source.
- Grants one requester at a time using round-robin. The granted command is latched and held until the processor accepts it. The completion response is then routed back to the owning requester only.
- An owner may keep the grant across consecutive commands (lock), for example to issue a tour X leg and its Y leg back to back.
- A response timeout guarantees the resource is always released.

Parameters:
- NUM_REQ, 3, number of requesters (2..8); index 0 = UART host.
- RESP_TIMEOUT, 2**20, cycles allowed in WAIT_RESP before forced release.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- req_rdy  in  NUM_REQ  per-requester command valid
- req_cmd  in  16*NUM_REQ  flattened commands; slice i = bits [16*i+15:16*i]
- req_lock  in  NUM_REQ  owner requests to retain the grant after the current response
- req_clr  out  NUM_REQ  one-cycle pulse: command of requester i latched
- resp_vld  out  NUM_REQ  one-cycle pulse: response for requester i available
- resp_out  out  8  latched response byte, valid with any resp_vld bit
- resp_err  out  1  qualifies resp_vld: 1 = timeout, not a real response
- grant  out  NUM_REQ  one-hot current owner; all-zero when no owner
- busy  out  1  high in every state except IDLE
- cmd  out  16  latched command to the processor
- cmd_rdy  out  1  command valid to the processor
- clr_cmd_rdy  in  1  processor accepted the command
- send_resp  in  1  processor finished the command
- resp  in  8  processor response byte, sampled with send_resp

Behaviour:
- Reset (rst high at posedge) puts all of the following at their reset values, including mid-transaction:
  - state = IDLE, rr_ptr = 0
  - grant = 0, cmd = 16'h0000, cmd_rdy = 0
  - req_clr = 0, resp_vld = 0, resp_out = 8'h00, resp_err = 0
  - timeout counter = 0
  - Any pending response is discarded.
- States: IDLE, ISSUE, WAIT_RESP, LOCKED. All outputs are registered.
- IDLE:
  - If any req_rdy is set, select the first set bit searching rr_ptr, rr_ptr+1, ... with wrap modulo NUM_REQ.
  - Next edge: cmd <= that requester's slice, grant <= one-hot(sel), req_clr[sel] pulses for 1 cycle, cmd_rdy <= 1, go to ISSUE.
  - Latency from req_rdy seen to cmd_rdy high is 1 cycle.
  - No request: hold state; stray clr_cmd_rdy / send_resp are ignored.
- ISSUE:
  - cmd_rdy stays high and cmd is stable until clr_cmd_rdy.
  - On clr_cmd_rdy: cmd_rdy <= 0, timeout counter <= 0, go to WAIT_RESP.
  - send_resp is ignored in ISSUE.
  - Changes on the requester's req_cmd have no effect on cmd.
- WAIT_RESP:
  - The counter increments every cycle; width is clog2(RESP_TIMEOUT+1).
  - On send_resp: resp_out <= resp, resp_err <= 0, resp_vld[owner] pulses for 1 cycle. Then:
    - if req_lock[owner] is sampled high in that cycle, go to LOCKED with grant unchanged;
    - otherwise grant <= 0, rr_ptr <= (owner+1) mod NUM_REQ, go to IDLE.
  - Timeout (counter == RESP_TIMEOUT-1 with no send_resp): resp_out <= 8'hFF, resp_err <= 1, resp_vld[owner] pulses, release as in the unlocked case. req_lock is ignored on timeout.
  - send_resp and timeout in the same cycle: send_resp wins.
- LOCKED:
  - Only the owner's req_rdy is honoured; other requests wait.
  - Owner req_rdy: latch cmd, pulse req_clr[owner], cmd_rdy <= 1, go to ISSUE.
  - Owner req_lock low with no req_rdy: release as in the unlocked case.
  - req_rdy and req_lock both high: issue (lock is re-evaluated at the next response).
- At most one bit of req_clr and of resp_vld is set in any cycle. grant is always one-hot or zero.
- rr_ptr is updated only on release, so a locked owner does not advance fairness.

Decomposition:
- Shared package cmd_pkg holds:
  - typedef enum arb_state_t {IDLE, ISSUE, WAIT_RESP, LOCKED};
  - localparam RESP_TIMEOUT_ERR = 8'hFF;
  - the response byte constants 8'hA5 (tour done) and 8'h5A (ack).
- One sub-module, rr_pick: purely combinational; inputs req and ptr, outputs one-hot sel and a found flag. It is verified standalone for every wrap position.

Test Plan:
- Single requester: req_rdy=3'b010, req_cmd[1]=16'h2012; clr_cmd_rdy 3 cycles after cmd_rdy; send_resp with resp=8'h5A 10 cycles later.
  -> cmd=16'h2012 and cmd_rdy high 1 cycle after the request; req_clr=3'b010 pulse; resp_vld=3'b010 pulse with resp_out=8'h5A and resp_err=0; grant returns to 0; rr_ptr=2.
- Fairness: all three req_rdy held high for 6 transactions from reset.
  -> grant sequence 001,010,100,001,010,100.
- Lock: requester 2 issues 16'h203F with req_lock=1, requester 0 pending.
  -> after the response, grant stays 100; requester 2's next command 16'h3001 is issued before requester 0; requester 0 is granted after lock drops.
- Timeout (RESP_TIMEOUT=16 in sim): clr_cmd_rdy given, no send_resp.
  -> exactly 16 cycles after entering WAIT_RESP: resp_vld pulse, resp_out=8'hFF, resp_err=1, busy=0.
- Collision: send_resp on the same cycle the timeout expires, resp=8'hA5.
  -> resp_out=8'hA5, resp_err=0.
- Reset mid-operation: rst high for 1 cycle during ISSUE and, separately, during WAIT_RESP.
  -> next cycle cmd_rdy=0, grant=0, busy=0, no resp_vld pulse; a subsequent request from requester 0 is granted first.

Source files
------------

// File: rtl/cmd_pkg.sv
// Shared types and constants for the command-processor arbiter.
// Imported by the arbiter top and its round-robin picker.
package cmd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RESP,
    LOCKED
  } arb_state_t;

  localparam logic [7:0] RESP_TIMEOUT_ERR = 8'hFF;
  localparam logic [7:0] RESP_TOUR_DONE   = 8'hA5;
  localparam logic [7:0] RESP_ACK         = 8'h5A;
  localparam int         MAX_REQ          = 8;

  function automatic logic [2:0] oh_to_idx(
    input logic [7:0] oh
  );
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/cmd_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping.
// Purely combinational; sel is one-hot or zero.
module rr_pick
  import cmd_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [N-1:0] req,
  input  logic [2:0]   ptr,
  output logic [N-1:0] sel,
  output logic         found
);

  int idx;

  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        sel[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cmd_arbiter.sv
// Round-robin arbiter sharing one command processor among requesters,
// with owner lock and a response timeout that forces release.
module cmd_arbiter
  import cmd_pkg::*;
#(
  parameter int NUM_REQ      = 3,
  parameter int RESP_TIMEOUT = 2**20
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_rdy,
  input  logic [16*NUM_REQ-1:0]  req_cmd,
  input  logic [NUM_REQ-1:0]     req_lock,
  output logic [NUM_REQ-1:0]     req_clr,
  output logic [NUM_REQ-1:0]     resp_vld,
  output logic [7:0]             resp_out,
  output logic                   resp_err,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   busy,
  output logic [15:0]            cmd,
  output logic                   cmd_rdy,
  input  logic                   clr_cmd_rdy,
  input  logic                   send_resp,
  input  logic [7:0]             resp
);

  localparam int CW = $clog2(RESP_TIMEOUT + 1);

  arb_state_t         state_q, state_d;
  logic [2:0]         rr_ptr_q, rr_ptr_d;
  logic [2:0]         owner_q, owner_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [15:0]        cmd_q, cmd_d;
  logic               cmd_rdy_q, cmd_rdy_d;
  logic [NUM_REQ-1:0] req_clr_q, req_clr_d;
  logic [NUM_REQ-1:0] resp_vld_q, resp_vld_d;
  logic [7:0]         resp_out_q, resp_out_d;
  logic               resp_err_q, resp_err_d;
  logic               busy_q, busy_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic [NUM_REQ-1:0] pick_sel;
  logic               pick_found;
  logic [2:0]         sel_idx;
  logic [2:0]         nxt_ptr;
  logic               timeout;

  rr_pick #(
    .N (NUM_REQ)
  ) u_pick (
    .req   (req_rdy),
    .ptr   (rr_ptr_q),
    .sel   (pick_sel),
    .found (pick_found)
  );

  assign sel_idx = oh_to_idx(8'(pick_sel));
  assign nxt_ptr = (int'(owner_q) == NUM_REQ - 1) ? 3'd0
                                                  : owner_q + 3'd1;
  assign timeout = (cnt_q == CW'(RESP_TIMEOUT - 1));

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    grant_d    = grant_q;
    cmd_d      = cmd_q;
    cmd_rdy_d  = cmd_rdy_q;
    req_clr_d  = '0;
    resp_vld_d = '0;
    resp_out_d = resp_out_q;
    resp_err_d = resp_err_q;
    cnt_d      = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          cmd_d     = req_cmd[16*int'(sel_idx) +: 16];
          grant_d   = pick_sel;
          owner_d   = sel_idx;
          req_clr_d = pick_sel;
          cmd_rdy_d = 1'b1;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        if (clr_cmd_rdy) begin
          cmd_rdy_d = 1'b0;
          cnt_d     = '0;
          state_d   = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        cnt_d = cnt_q + CW'(1);
        if (send_resp) begin
          resp_out_d = resp;
          resp_err_d = 1'b0;
          resp_vld_d = grant_q;
          if (req_lock[owner_q]) begin
            state_d = LOCKED;
          end else begin
            grant_d  = '0;
            rr_ptr_d = nxt_ptr;
            state_d  = IDLE;
          end
        end else if (timeout) begin
          resp_out_d = RESP_TIMEOUT_ERR;
          resp_err_d = 1'b1;
          resp_vld_d = grant_q;
          grant_d    = '0;
          rr_ptr_d   = nxt_ptr;
          state_d    = IDLE;
        end
      end
      LOCKED: begin
        // only the owner may issue while the lock is held
        if (req_rdy[owner_q]) begin
          cmd_d     = req_cmd[16*int'(owner_q) +: 16];
          req_clr_d = grant_q;
          cmd_rdy_d = 1'b1;
          state_d   = ISSUE;
        end else if (!req_lock[owner_q]) begin
          grant_d  = '0;
          rr_ptr_d = nxt_ptr;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      grant_q    <= '0;
      cmd_q      <= '0;
      cmd_rdy_q  <= 1'b0;
      req_clr_q  <= '0;
      resp_vld_q <= '0;
      resp_out_q <= '0;
      resp_err_q <= 1'b0;
      busy_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      grant_q    <= grant_d;
      cmd_q      <= cmd_d;
      cmd_rdy_q  <= cmd_rdy_d;
      req_clr_q  <= req_clr_d;
      resp_vld_q <= resp_vld_d;
      resp_out_q <= resp_out_d;
      resp_err_q <= resp_err_d;
      busy_q     <= busy_d;
      cnt_q      <= cnt_d;
    end
  end

  assign req_clr  = req_clr_q;
  assign resp_vld = resp_vld_q;
  assign resp_out = resp_out_q;
  assign resp_err = resp_err_q;
  assign grant    = grant_q;
  assign busy     = busy_q;
  assign cmd      = cmd_q;
  assign cmd_rdy  = cmd_rdy_q;

endmodule

// File: tb/tb_cmd_arbiter.sv
// Directed bench for cmd_arbiter with a short response timeout.
module tb_cmd_arbiter;

  localparam int N  = 3;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_rdy;
  logic [16*N-1:0] req_cmd;
  logic [N-1:0]    req_lock;
  logic [N-1:0]    req_clr;
  logic [N-1:0]    resp_vld;
  logic [7:0]      resp_out;
  logic            resp_err;
  logic [N-1:0]    grant;
  logic            busy;
  logic [15:0]     cmd;
  logic            cmd_rdy;
  logic            clr_cmd_rdy;
  logic            send_resp;
  logic [7:0]      resp;

  logic [N-1:0]    p_req;
  logic [2:0]      p_ptr;
  logic [N-1:0]    p_sel;
  logic            p_found;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cmd_arbiter #(
    .NUM_REQ      (N),
    .RESP_TIMEOUT (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_rdy     (req_rdy),
    .req_cmd     (req_cmd),
    .req_lock    (req_lock),
    .req_clr     (req_clr),
    .resp_vld    (resp_vld),
    .resp_out    (resp_out),
    .resp_err    (resp_err),
    .grant       (grant),
    .busy        (busy),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .send_resp   (send_resp),
    .resp        (resp)
  );

  rr_pick #(.N(N)) u_pick (
    .req   (p_req),
    .ptr   (p_ptr),
    .sel   (p_sel),
    .found (p_found)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  int e;
  logic [N-1:0] exp_g;

  initial begin
    rst = 1'b1;
    req_rdy = '0;
    req_cmd = '0;
    req_lock = '0;
    clr_cmd_rdy = 1'b0;
    send_resp = 1'b0;
    resp = '0;
    p_req = '0;
    p_ptr = '0;

    // standalone picker, every pointer and request pattern
    for (int p = 0; p < N; p++) begin
      for (int r = 0; r < (1 << N); r++) begin
        p_req = N'(r);
        p_ptr = 3'(p);
        e = -1;
        for (int k = N - 1; k >= 0; k--) begin
          if (r[(p + k) % N]) e = (p + k) % N;
        end
        #1;
        chk("pick_found", 32'(p_found), 32'(e >= 0));
        chk("pick_sel", 32'(p_sel), (e >= 0) ? 32'(1 << e) : 32'd0);
      end
    end

    do_reset();
    chk("rst_grant", 32'(grant), 0);
    chk("rst_cmd", 32'(cmd), 0);
    chk("rst_cmd_rdy", 32'(cmd_rdy), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_resp_out", 32'(resp_out), 0);
    chk("rst_resp_err", 32'(resp_err), 0);
    chk("rst_req_clr", 32'(req_clr), 0);
    chk("rst_resp_vld", 32'(resp_vld), 0);

    // stray processor handshakes in IDLE do nothing
    clr_cmd_rdy = 1'b1;
    send_resp = 1'b1;
    tick();
    clr_cmd_rdy = 1'b0;
    send_resp = 1'b0;
    chk("idle_stray_busy", 32'(busy), 0);
    chk("idle_stray_vld", 32'(resp_vld), 0);

    // single requester
    req_rdy = 3'b010;
    req_cmd[31:16] = 16'h2012;
    tick();
    chk("s_cmd", 32'(cmd), 32'h2012);
    chk("s_cmd_rdy", 32'(cmd_rdy), 1);
    chk("s_req_clr", 32'(req_clr), 32'b010);
    chk("s_grant", 32'(grant), 32'b010);
    chk("s_busy", 32'(busy), 1);
    req_rdy = '0;
    req_cmd[31:16] = 16'hDEAD;
    send_resp = 1'b1;
    tick();
    send_resp = 1'b0;
    chk("s_clr_pulse", 32'(req_clr), 0);
    chk("s_cmd_hold", 32'(cmd), 32'h2012);
    chk("s_no_early_resp", 32'(resp_vld), 0);
    tick();
    clr_cmd_rdy = 1'b1;
    tick();
    clr_cmd_rdy = 1'b0;
    chk("s_cmd_rdy_low", 32'(cmd_rdy), 0);
    repeat (9) tick();
    send_resp = 1'b1;
    resp = 8'h5A;
    tick();
    send_resp = 1'b0;
    chk("s_resp_vld", 32'(resp_vld), 32'b010);
    chk("s_resp_out", 32'(resp_out), 32'h5A);
    chk("s_resp_err", 32'(resp_err), 0);
    chk("s_grant_rel", 32'(grant), 0);
    chk("s_busy_rel", 32'(busy), 0);
    chk("s_rr_ptr", 32'(dut.rr_ptr_q), 2);
    tick();
    chk("s_vld_pulse", 32'(resp_vld), 0);

    // lock: requester 2 keeps the grant while requester 0 waits
    req_rdy = 3'b101;
    req_lock = 3'b100;
    req_cmd[47:32] = 16'h203F;
    req_cmd[15:0] = 16'h1111;
    tick();
    chk("l_grant", 32'(grant), 32'b100);
    chk("l_cmd", 32'(cmd), 32'h203F);
    req_rdy = 3'b001;
    req_cmd[47:32] = 16'h3001;
    clr_cmd_rdy = 1'b1;
    tick();
    clr_cmd_rdy = 1'b0;
    send_resp = 1'b1;
    resp = 8'hA5;
    tick();
    send_resp = 1'b0;
    chk("l_resp_vld", 32'(resp_vld), 32'b100);
    chk("l_grant_kept", 32'(grant), 32'b100);
    chk("l_busy", 32'(busy), 1);
    tick();
    chk("l_other_wait", 32'(grant), 32'b100);
    chk("l_no_clr", 32'(req_clr), 0);
    req_rdy = 3'b101;
    tick();
    chk("l_cmd2", 32'(cmd), 32'h3001);
    chk("l_clr2", 32'(req_clr), 32'b100);
    chk("l_cmd_rdy2", 32'(cmd_rdy), 1);
    req_rdy = 3'b001;
    req_lock = '0;
    clr_cmd_rdy = 1'b1;
    tick();
    clr_cmd_rdy = 1'b0;
    send_resp = 1'b1;
    resp = 8'h5A;
    tick();
    send_resp = 1'b0;
    chk("l_rel_grant", 32'(grant), 0);
    chk("l_rr_ptr", 32'(dut.rr_ptr_q), 0);
    tick();
    chk("l_r0_grant", 32'(grant), 32'b001);
    chk("l_r0_cmd", 32'(cmd), 32'h1111);
    req_rdy = '0;
    clr_cmd_rdy = 1'b1;
    tick();
    clr_cmd_rdy = 1'b0;
    send_resp = 1'b1;
    tick();
    send_resp = 1'b0;

    // timeout with no response, lock ignored
    req_rdy = 3'b010;
    req_lock = 3'b010;
    req_cmd[31:16] = 16'h2012;
    tick();
    req_rdy = '0;
    clr_cmd_rdy = 1'b1;
    tick();
    clr_cmd_rdy = 1'b0;
    repeat (TO - 1) tick();
    chk("t_no_early", 32'(resp_vld), 0);
    chk("t_busy_before", 32'(busy), 1);
    tick();
    chk("t_resp_vld", 32'(resp_vld), 32'b010);
    chk("t_resp_out", 32'(resp_out), 32'hFF);
    chk("t_resp_err", 32'(resp_err), 1);
    chk("t_busy", 32'(busy), 0);
    chk("t_grant", 32'(grant), 0);
    req_lock = '0;

    // response collides with timeout expiry
    req_rdy = 3'b010;
    tick();
    req_rdy = '0;
    clr_cmd_rdy = 1'b1;
    tick();
    clr_cmd_rdy = 1'b0;
    repeat (TO - 1) tick();
    send_resp = 1'b1;
    resp = 8'hA5;
    tick();
    send_resp = 1'b0;
    chk("c_resp_vld", 32'(resp_vld), 32'b010);
    chk("c_resp_out", 32'(resp_out), 32'hA5);
    chk("c_resp_err", 32'(resp_err), 0);

    // reset during ISSUE
    req_rdy = 3'b100;
    tick();
    req_rdy = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("ri_cmd_rdy", 32'(cmd_rdy), 0);
    chk("ri_grant", 32'(grant), 0);
    chk("ri_busy", 32'(busy), 0);

    // reset during WAIT_RESP with a response arriving
    req_rdy = 3'b100;
    tick();
    req_rdy = '0;
    clr_cmd_rdy = 1'b1;
    tick();
    clr_cmd_rdy = 1'b0;
    tick();
    rst = 1'b1;
    send_resp = 1'b1;
    resp = 8'h5A;
    tick();
    rst = 1'b0;
    send_resp = 1'b0;
    chk("rw_cmd_rdy", 32'(cmd_rdy), 0);
    chk("rw_grant", 32'(grant), 0);
    chk("rw_busy", 32'(busy), 0);
    chk("rw_resp_vld", 32'(resp_vld), 0);
    chk("rw_resp_out", 32'(resp_out), 0);
    tick();
    chk("rw_no_late_vld", 32'(resp_vld), 0);
    req_rdy = 3'b101;
    tick();
    chk("rw_r0_first", 32'(grant), 32'b001);

    // fairness from reset with all requesters active
    do_reset();
    req_rdy = 3'b111;
    req_cmd = {16'hC002, 16'hC001, 16'hC000};
    for (int t = 0; t < 6; t++) begin
      exp_g = N'(1 << (t % N));
      tick();
      chk("f_grant", 32'(grant), 32'(exp_g));
      chk("f_cmd", 32'(cmd), 32'hC000 + 32'(t % N));
      clr_cmd_rdy = 1'b1;
      tick();
      clr_cmd_rdy = 1'b0;
      send_resp = 1'b1;
      tick();
      send_resp = 1'b0;
      chk("f_resp_vld", 32'(resp_vld), 32'(exp_g));
    end
    req_rdy = '0;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
